// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array feeder and its neighbours.
package sa_pkg;

    // Default lane width used when a block does not override W.
    localparam int unsigned W_DEFAULT = 8;

    typedef logic [W_DEFAULT-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // Zero-injection cycles after the last beat: a value entering the west or
    // north edge needs up to 2N cycles to reach the far-corner PE.
    function automatic int unsigned drain_cycles(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Beat input stream of the skew feeder: one column of A and one row of B.
// Handshake: a beat transfers on a rising clock edge where in_valid and
// in_ready are both high; in_ready never depends combinationally on in_valid,
// and the master holds in_a/in_b stable while in_valid is high.
interface sa_skew_feeder_if #(
    parameter int N = 32,
    parameter int W = 8
) ();
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] in_a;
    logic [N-1:0][W-1:0] in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/sa_skew_feeder_skew_line.sv
// Reset-cleared shift chain of DEPTH registers; output is the value that
// entered DEPTH edges ago.
module skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);
    logic [DEPTH-1:0][W-1:0] chain_q;

    // Shift every cycle, unconditionally; stage 0 takes the new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= din_i;
            for (int k = 1; k < DEPTH; k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    assign dout_o = chain_q[DEPTH-1];
endmodule

// File: rtl/sa_skew_feeder.sv
// Feeder for the N x N systolic array: accepts K beats, skews lane i by i
// cycles onto the west/north edges, drains zeros for 2N cycles, pulses done.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int N = 32,
    parameter int W = int'(W_DEFAULT),
    parameter int K = N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    sa_skew_feeder_if.slave     in_if,
    output logic [N-1:0][W-1:0] a_out,
    output logic [N-1:0][W-1:0] b_out,
    output logic                clear_acc,
    output logic                busy,
    output logic                done,
    output feeder_state_t       dbg_state
);
    localparam int DRAIN_LEN = int'(drain_cycles(N));
    localparam int BEAT_W    = $clog2(K + 1);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    feeder_state_t       state_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [BEAT_W-1:0]   beat_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic [DRAIN_W-1:0]  drain_cnt_d;
    logic                in_ready_q;
    logic                clear_acc_q;
    logic                busy_q;
    logic                done_q;
    logic                accept;
    logic                last_beat;
    logic [N-1:0][W-1:0] inj_a;
    logic [N-1:0][W-1:0] inj_b;

    assign accept      = in_if.in_valid && in_ready_q;
    assign beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
    assign last_beat   = (beat_cnt_q == BEAT_W'(K - 1));
    assign drain_cnt_d = drain_cnt_q + DRAIN_W'(1);

    // Only an accepted beat enters the skew lines; every other cycle is zero.
    always_comb begin
        inj_a = '0;
        inj_b = '0;
        if (accept) begin
            inj_a = in_if.in_a;
            inj_b = in_if.in_b;
        end
    end

    // Operation sequencing with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            clear_acc_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            clear_acc_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= LOAD;
                        beat_cnt_q  <= '0;
                        in_ready_q  <= 1'b1;
                        clear_acc_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (last_beat) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_d;
                    if (drain_cnt_d == DRAIN_W'(DRAIN_LEN)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Lane i of each edge is delayed by i+1 registers.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        skew_line #(.W(W), .DEPTH(gi + 1)) u_skew_a (
            .clk    (clk),
            .rst    (rst),
            .din_i  (inj_a[gi]),
            .dout_o (a_out[gi])
        );
        skew_line #(.W(W), .DEPTH(gi + 1)) u_skew_b (
            .clk    (clk),
            .rst    (rst),
            .din_i  (inj_b[gi]),
            .dout_o (b_out[gi])
        );
    end

    assign in_if.in_ready = in_ready_q;
    assign clear_acc      = clear_acc_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder (N=4, K=4): timeline model, per-cycle compare,
// directed scenarios with literal expectations, then randomized operations.
module tb_sa_skew_feeder;
    import sa_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int K     = 4;
    localparam int DRAIN = 2 * N;
    localparam int MAXE  = 8192;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    sa_skew_feeder_if #(.N(N), .W(W)) in_if ();

    logic [N-1:0][W-1:0] a_out;
    logic [N-1:0][W-1:0] b_out;
    logic                clear_acc;
    logic                busy;
    logic                done;
    feeder_state_t       dbg_state;

    sa_skew_feeder #(.N(N), .W(W), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_if     (in_if),
        .a_out     (a_out),
        .b_out     (b_out),
        .clear_acc (clear_acc),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (operation timeline) ----------------
    int  e_cnt      = 0;
    int  reset_edge = 0;
    bit  m_active   = 1'b0;
    int  m_s        = 0;
    int  m_beats    = 0;
    int  m_tl       = 0;
    logic [N-1:0][W-1:0] hist_a [MAXE];
    logic [N-1:0][W-1:0] hist_b [MAXE];

    logic                exp_in_ready = 1'b0;
    logic                exp_clear    = 1'b0;
    logic                exp_busy     = 1'b0;
    logic                exp_done     = 1'b0;
    logic [N-1:0][W-1:0] exp_a        = '0;
    logic [N-1:0][W-1:0] exp_b        = '0;

    always @(posedge clk) begin : model
        logic acc;
        e_cnt++;
        if (e_cnt >= MAXE - 4) begin
            $display("FAIL edge_budget: got %0d expected below %0d", e_cnt, MAXE - 4);
            $fatal(1, "edge budget exhausted");
        end
        if (!rst) begin
            reset_edge   = e_cnt;
            m_active     = 1'b0;
            hist_a[e_cnt] = '0;
            hist_b[e_cnt] = '0;
            exp_in_ready = 1'b0;
            exp_clear    = 1'b0;
            exp_busy     = 1'b0;
            exp_done     = 1'b0;
            exp_a        = '0;
            exp_b        = '0;
        end else begin
            acc = in_if.in_valid && exp_in_ready;
            hist_a[e_cnt] = acc ? in_if.in_a : '0;
            hist_b[e_cnt] = acc ? in_if.in_b : '0;
            if (acc) begin
                m_beats++;
                if (m_beats == K) m_tl = e_cnt;
            end
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_s      = e_cnt;
                    m_beats  = 0;
                end
            end else if (m_beats == K && e_cnt == m_tl + DRAIN + 1) begin
                m_active = 1'b0;
            end
            exp_in_ready = m_active && (m_beats < K);
            exp_clear    = m_active && (e_cnt == m_s);
            exp_busy     = m_active;
            exp_done     = m_active && (m_beats == K) && (e_cnt == m_tl + DRAIN);
            for (int i = 0; i < N; i++) begin
                exp_a[i] = (e_cnt - i > reset_edge) ? hist_a[e_cnt - i][i] : '0;
                exp_b[i] = (e_cnt - i > reset_edge) ? hist_b[e_cnt - i][i] : '0;
            end
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    logic [N-1:0][W-1:0] rec_a [MAXE];
    logic [N-1:0][W-1:0] rec_b [MAXE];
    int obs_acc       = 0;
    int obs_last_acc  = 0;
    int obs_done_cnt  = 0;
    int obs_done_edge = 0;
    int obs_clear     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_in_ready", in_if.in_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_clear_acc", clear_acc, 0);
            check("rst_done", done, 0);
            check("rst_a_out", a_out, 0);
            check("rst_b_out", b_out, 0);
        end else begin
            check("in_ready", in_if.in_ready, exp_in_ready);
            check("busy", busy, exp_busy);
            check("clear_acc", clear_acc, exp_clear);
            check("done", done, exp_done);
            check("a_out", a_out, exp_a);
            check("b_out", b_out, exp_b);
            check("state_idle", dbg_state == IDLE, !exp_busy);
        end
        rec_a[e_cnt] = a_out;
        rec_b[e_cnt] = b_out;
        if (in_if.in_valid && in_if.in_ready) begin
            obs_acc++;
            obs_last_acc = e_cnt + 1;
        end
        if (done) begin
            obs_done_cnt++;
            obs_done_edge = e_cnt;
        end
        if (clear_acc) obs_clear++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N-1:0][W-1:0] rand_vec();
        logic [N-1:0][W-1:0] v;
        for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    function automatic logic [N-1:0][W-1:0] ident_col(input int k);
        logic [N-1:0][W-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (i == k) ? W'(1) : W'(0);
        return v;
    endfunction

    function automatic logic [N-1:0][W-1:0] b_row(input int k);
        logic [N-1:0][W-1:0] v;
        for (int j = 0; j < N; j++) v[j] = W'(N * k + j + 1);
        return v;
    endfunction

    task automatic clear_obs();
        obs_acc       = 0;
        obs_last_acc  = 0;
        obs_done_cnt  = 0;
        obs_done_edge = 0;
        obs_clear     = 0;
    endtask

    task automatic wait_done(input bit glitch);
        int cyc;
        cyc = 0;
        while (obs_done_cnt == 0 && cyc < 300) begin
            start = glitch && (cyc == 3);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("done_seen", obs_done_cnt > 0, 1);
    endtask

    task automatic op_checks();
        check("beats_accepted", obs_acc, K);
        check("done_gap", obs_done_edge - obs_last_acc, DRAIN);
        check("done_pulses", obs_done_cnt, 1);
        check("clear_pulses", obs_clear, 1);
    endtask

    // vmode: 0 back-to-back, 1 two bubbles after beat 1, 2 random valid,
    //        3 valid held high throughout
    task automatic do_op(input int vmode, input bit glitch, input bit ident);
        int  sent;
        int  cyc;
        int  bub;
        int  s_edge;
        bit  v;
        int  sum;
        int  ub;
        sent = 0;
        cyc  = 0;
        bub  = 0;
        clear_obs();
        start  = 1'b1;
        s_edge = e_cnt + 1;
        tick();
        start = 1'b0;
        while (sent < K && cyc < 200) begin
            case (vmode)
                1:       v = !(sent == 2 && bub < 2);
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            if (vmode == 1 && sent == 2 && bub < 2) bub++;
            in_if.in_valid = v;
            in_if.in_a     = ident ? ident_col(sent) : rand_vec();
            in_if.in_b     = ident ? b_row(sent)     : rand_vec();
            start          = glitch && (cyc == 1);
            tick();
            cyc++;
            if (obs_acc > sent) sent = obs_acc;
        end
        start          = 1'b0;
        in_if.in_valid = (vmode == 3);
        wait_done(glitch);
        in_if.in_valid = 1'b0;
        tick();
        tick();
        op_checks();
        if (ident) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    sum = 0;
                    for (int u = s_edge; u <= obs_done_edge; u++) begin
                        ub = u + j - i;
                        if (ub >= 0 && ub < MAXE) sum += int'(rec_a[u][i]) * int'(rec_b[ub][j]);
                    end
                    check($sformatf("c[%0d][%0d]", i, j), sum, N * i + j + 1);
                end
            end
        end
    endtask

    task automatic skew_test();
        clear_obs();
        start = 1'b1;
        tick();
        start          = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.in_a     = {8'd4, 8'd3, 8'd2, 8'd1};
        in_if.in_b     = {8'd8, 8'd7, 8'd6, 8'd5};
        tick();
        in_if.in_valid = 1'b0;
        @(negedge clk);
        check("skew_a_t0", a_out, 32'h0000_0001);
        check("skew_b_t0", b_out, 32'h0000_0005);
        tick();
        tick();
        @(negedge clk);
        check("skew_b2_t2", b_out, 32'h0007_0000);
        tick();
        @(negedge clk);
        check("skew_a3_t3", a_out, 32'h0400_0000);
        tick();
        in_if.in_valid = 1'b1;
        for (int k = 1; k < K; k++) begin
            in_if.in_a = rand_vec();
            in_if.in_b = rand_vec();
            tick();
        end
        in_if.in_valid = 1'b0;
        wait_done(1'b0);
        tick();
        tick();
        op_checks();
    endtask

    task automatic reset_mid_drain();
        clear_obs();
        start = 1'b1;
        tick();
        start          = 1'b0;
        in_if.in_valid = 1'b1;
        for (int k = 0; k < K; k++) begin
            in_if.in_a = rand_vec();
            in_if.in_b = rand_vec();
            tick();
        end
        in_if.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_a_out", a_out, 0);
        check("mid_rst_b_out", b_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_if.in_ready, 0);
        tick();
        tick();
        rst = 1'b1;
        repeat (30) tick();
        check("mid_rst_no_done", obs_done_cnt, 0);
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_a     = '0;
        in_if.in_b     = '0;
        rst            = 1'b0;
        repeat (4) begin
            tick();
            start          = 1'($urandom_range(0, 1));
            in_if.in_valid = 1'($urandom_range(0, 1));
            in_if.in_a     = rand_vec();
            in_if.in_b     = rand_vec();
        end
        @(negedge clk);
        check("reset_a_out", a_out, 0);
        check("reset_done", done, 0);
        tick();
        rst            = 1'b1;
        start          = 1'b0;
        in_if.in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_if.in_ready, 0);
        check("post_reset_busy", busy, 0);
        tick();
        tick();

        skew_test();
        do_op(1, 1'b0, 1'b1);
        do_op(0, 1'b1, 1'b0);
        reset_mid_drain();
        do_op(0, 1'b0, 1'b0);
        do_op(3, 1'b0, 1'b0);
        repeat (25) begin
            do_op($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
